fetch_issue: RTL
================

FETCH_ISSUE -- requirements
Module: fetch_issue

Interface
REQ-001 SHALL have parameter PC_W, default 8, instruction-memory word-address width.
REQ-002 SHALL have parameter INSTR_W, default 32, instruction width; opcode occupies bits [INSTR_W-1 -: 5].
REQ-003 SHALL have parameter BUF_DEPTH, default 2, issue-buffer entries (power of two, >=2).
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port imem_rd, output, 1, fetch request to instruction memory.
REQ-007 SHALL have port imem_addr, output, PC_W, fetch address, valid with imem_rd.
REQ-008 SHALL have port imem_data, input, INSTR_W, read data returned exactly one cycle after imem_rd.
REQ-009 SHALL have port stall, input, 1, decode stage holds current issued instruction.
REQ-010 SHALL have port redirect, input, 1, taken branch or jump; flush and refetch.
REQ-011 SHALL have port redirect_pc, input, PC_W, new fetch address, sampled when redirect=1.
REQ-012 SHALL have port instr_out, output, INSTR_W, issued instruction word.
REQ-013 SHALL have port opcode_out, output, 5, opcode field of instr_out; 5'b00000 (stall/bubble) when not valid.
REQ-014 SHALL have port pc_out, output, PC_W, address of issued instruction.
REQ-015 SHALL have port instr_valid, output, 1, instr_out/pc_out are a real instruction.

Function
REQ-016 SHALL keep fetch PC; each accepted fetch (imem_rd=1, no redirect) increments PC by 1 modulo 2^PC_W (wrap 2^PC_W-1 -> 0).
REQ-017 SHALL assert imem_rd only when buffer occupancy plus in-flight requests < BUF_DEPTH, preventing overflow under stall.
REQ-018 SHALL push returned imem_data with its address into the buffer the cycle after the request, unless discarded by REQ-022.
REQ-019 SHALL present buffer head registered on instr_out/pc_out/instr_valid; head pops at a clock edge where instr_valid=1 and stall=0.
REQ-020 SHALL issue a bubble (instr_valid=0, opcode_out=00000, instr_out=0) when buffer empty and stall=0.
REQ-021 SHALL hold instr_out, opcode_out, pc_out, instr_valid stable while stall=1 and redirect=0.
REQ-022 On redirect=1: next edge sets PC=redirect_pc, empties buffer, marks in-flight response as discard, outputs bubble; imem_rd for redirect_pc asserted the following cycle.
REQ-023 SHALL give redirect priority over stall when both asserted the same cycle.
REQ-024 Redirect on consecutive cycles: last redirect_pc wins; every earlier in-flight response discarded.
REQ-025 Minimum latency: redirect edge to first valid instruction from redirect_pc = 3 cycles (request, memory return, issue).
REQ-026 SHALL implement states FLUSH (after reset/redirect, no request outstanding), RUN (normal); FLUSH -> RUN after one cycle; RUN -> FLUSH on redirect.

Reset
REQ-027 rst_n=0 SHALL asynchronously set PC=0, buffer empty, no in-flight, state FLUSH, imem_rd=0, imem_addr=0, instr_out=0, opcode_out=00000, pc_out=0, instr_valid=0.
REQ-028 Reset mid-fetch SHALL discard outstanding response; first request after release fetches address 0.

Configuration
REQ-029 Macro FETCH_PERF_CNT_EN defined: SHALL add outputs issue_cnt (32) counting popped valid instructions and bubble_cnt (32) counting bubble cycles with stall=0; both reset to 0, saturate at 2^32-1.
REQ-030 Macro FETCH_PERF_CNT_EN undefined: ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-031 Shared package SHALL hold opcode constants (ADD 00001, XOR 00101, CMP 01011, MOVI 00011, MOV 10010, LW 01101, SW 01111, BEQ 01100, ADDI 10011, NOP 00000) and PC_W/INSTR_W defaults, also used by the control decoder.
REQ-032 Issue buffer SHALL be a sub-module fetch_buf (synchronous FIFO, push/pop/flush, count output).

Verification
REQ-033 Reset release, memory holds ADD at 0, XOR at 1 -> imem_addr 0,1,2...; instr_valid first high cycle 3, opcode_out 00001 then 00101, pc_out 0 then 1.
REQ-034 stall=1 for 4 cycles while issuing pc 5 -> outputs held at pc 5; imem_rd stops after buffer full; resume issues pc 6, 7 with no gap or duplicate.
REQ-035 redirect=1, redirect_pc=0x40 while pc 9 issued and 10 in flight -> pc 10 never issued; bubble opcode 00000; pc 0x40 valid exactly 3 cycles after redirect.
REQ-036 redirect and stall both 1 same cycle -> redirect taken per REQ-022.
REQ-037 PC at 0xFF -> next fetch imem_addr 0x00; pc_out issues 0xFF then 0x00.
REQ-038 rst_n pulsed low mid-run with response in flight -> all outputs zero immediately; post-release first issued pc_out=0; with FETCH_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/fetch_issue_pkg.sv
// Shared constants for the fetch/issue front end and the control decoder.
package fetch_issue_pkg;

    localparam int PC_W_DEF    = 8;
    localparam int INSTR_W_DEF = 32;
    localparam int OPC_W       = 5;

    typedef logic [OPC_W-1:0] opcode_t;

    localparam opcode_t OP_NOP  = 5'b00000;
    localparam opcode_t OP_ADD  = 5'b00001;
    localparam opcode_t OP_MOVI = 5'b00011;
    localparam opcode_t OP_XOR  = 5'b00101;
    localparam opcode_t OP_CMP  = 5'b01011;
    localparam opcode_t OP_BEQ  = 5'b01100;
    localparam opcode_t OP_LW   = 5'b01101;
    localparam opcode_t OP_SW   = 5'b01111;
    localparam opcode_t OP_MOV  = 5'b10010;
    localparam opcode_t OP_ADDI = 5'b10011;

endpackage

// File: rtl/fetch_buf.sv
// Issue buffer: synchronous FIFO with flush and an occupancy count.
// Flush wins over push/pop in the same cycle.
module fetch_buf #(
    parameter int DEPTH = 2,
    parameter int W     = 40
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_issue.sv
// Fetch/issue front end: PC, one-cycle imem, issue buffer, redirect flush.
// Define FETCH_PERF_CNT_EN to add issue_cnt/bubble_cnt counters.
module fetch_issue
    import fetch_issue_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int INSTR_W   = INSTR_W_DEF,
    parameter int BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_rd,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [INSTR_W-1:0] instr_out,
    output logic [OPC_W-1:0]   opcode_out,
    output logic [PC_W-1:0]    pc_out,
    output logic               instr_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        issue_cnt,
    output logic [31:0]        bubble_cnt
`endif
);
    localparam logic [0:0] S_FLUSH = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int EW = PC_W + INSTR_W;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(BUF_DEPTH);

    logic [0:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d;
    logic [CW-1:0]   count;
    logic [EW-1:0]   head;
    logic [CW:0]     occ;
    logic            pop;

    fetch_buf #(
        .DEPTH (BUF_DEPTH),
        .W     (EW)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q),
        .pop   (pop),
        .flush (redirect),
        .din   ({req_pc_q, imem_data}),
        .dout  (head),
        .count (count)
    );

    // Occupancy credits the pop happening at this edge, so the
    // buffer can stream one instruction per cycle at depth 2.
    always_comb begin
        instr_valid = (count != '0);
        pop         = instr_valid && !stall;
        occ         = {1'b0, count} + {{CW{1'b0}}, inflight_q}
                    - {{CW{1'b0}}, pop};
        imem_rd     = (state_q == S_RUN) && (occ < DEPTH_V);
        imem_addr   = pc_q;
        instr_out   = instr_valid ? head[INSTR_W-1:0] : '0;
        pc_out      = instr_valid ? head[EW-1 -: PC_W] : '0;
        opcode_out  = instr_out[INSTR_W-1 -: OPC_W];
    end

    always_comb begin
        state_d    = (state_q == S_FLUSH) ? S_RUN : state_q;
        pc_d       = imem_rd ? pc_q + PC_W'(1) : pc_q;
        inflight_d = imem_rd;
        req_pc_d   = pc_q;
        if (redirect) begin
            state_d    = S_FLUSH;
            pc_d       = redirect_pc;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FLUSH;
            pc_q       <= '0;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] issue_cnt_q, issue_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        issue_cnt_d  = issue_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (pop && (issue_cnt_q != '1)) begin
            issue_cnt_d = issue_cnt_q + 32'd1;
        end
        if (!instr_valid && !stall && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            issue_cnt_q  <= issue_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign issue_cnt  = issue_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
